// File: rtl/bram1_server.sv
// bram1_server: credit-based command/response front end for a single-port BRAM.
// Read data returns through a small FIFO sized so the requester can never overrun it.
module bram1_server #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do,
  output logic                  busy
);
  localparam int L  = 1 + PIPELINED;
  localparam int D  = L + 2;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  logic [L-1:0]          flag_q, flag_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d, infl_cnt_q, infl_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [D];
  logic [DATA_WIDTH-1:0] mem_d [D];
  logic [CW:0]           credit_used;
  logic                  accept, rd_acc, push, pop;
  // Credit counts every read from accept until pop, so the FIFO always has room
  assign credit_used = (CW+1)'(infl_cnt_q) + (CW+1)'(fifo_cnt_q);
  assign req_ready   = RST_N & (credit_used < (CW+1)'(D));
  assign accept      = req_valid & req_ready;
  assign rd_acc      = accept & ~req_write;
  assign push        = flag_q[L-1];
  assign rsp_valid   = RST_N & (fifo_cnt_q != '0);
  assign pop         = rsp_valid & rsp_ready;
  assign rsp_data    = mem_q[rd_ptr_q];
  assign busy        = RST_N & ((|flag_q) | (fifo_cnt_q != '0));
  assign bram_en     = accept;
  assign bram_we     = accept & req_write;
  assign bram_addr   = req_addr;
  assign bram_di     = req_data;
  always_comb begin
    flag_d     = flag_q << 1;
    flag_d[0]  = rd_acc;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = bram_do;
    wr_ptr_d   = !push ? wr_ptr_q : (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d   = !pop  ? rd_ptr_q : (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    infl_cnt_d = infl_cnt_q + CW'(rd_acc) - CW'(push);
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      flag_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      infl_cnt_q <= '0;
    end else begin
      flag_q     <= flag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      infl_cnt_q <= infl_cnt_d;
    end
  end
  always_ff @(posedge CLK) mem_q <= mem_d;
  always_ff @(posedge CLK)
    if (RST_N) assert (!(push && fifo_cnt_q == CW'(D))) else $error("bram1_server: push into full response FIFO");
endmodule

// File: doc/bram1_server.md
BRAM1_SERVER -- requirements
Module: bram1_server

Interface
REQ-001 Parameter PIPELINED, default 0: read latency of the attached single-port BRAM; 0 means 1 cycle, 1 means 2 cycles; L = 1 + PIPELINED.
REQ-002 Parameter ADDR_WIDTH, default 1: BRAM address width.
REQ-003 Parameter DATA_WIDTH, default 1: BRAM data width.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  requester presents a command.
REQ-007 req_ready  output  1  block accepts the command this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH  command address.
REQ-010 req_data  input  DATA_WIDTH  write data; ignored for reads.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  consumer takes the read data.
REQ-013 rsp_data  output  DATA_WIDTH  read data, in request order.
REQ-014 bram_en  output  1  to BRAM EN.
REQ-015 bram_we  output  1  to BRAM WE.
REQ-016 bram_addr  output  ADDR_WIDTH  to BRAM ADDR.
REQ-017 bram_di  output  DATA_WIDTH  to BRAM DI.
REQ-018 bram_do  input  DATA_WIDTH  from BRAM DO.
REQ-019 busy  output  1  reads in flight or buffered.

Function
REQ-020 Accept = req_valid & req_ready; a command transfers only on accept.
REQ-021 bram_en SHALL equal accept; bram_we SHALL equal accept & req_write; bram_addr = req_addr and bram_di = req_data, combinational pass-through.
REQ-022 In-flight tracker: L-stage shift register of read flags; stage 0 loads (accept & ~req_write) each cycle; a flag leaving stage L-1 marks bram_do valid that cycle.
REQ-023 Response FIFO: depth D = L + 2, DATA_WIDTH wide; push bram_do when the stage L-1 flag is set; pop on rsp_valid & rsp_ready.
REQ-024 rsp_valid = FIFO not empty; rsp_data = FIFO head, registered storage, no combinational path from bram_do.
REQ-025 Credit rule: req_ready = (inflight_count + fifo_count) < D, using registered counts only; req_ready SHALL NOT depend combinationally on req_valid, req_write, or rsp_ready.
REQ-026 Writes and reads share the same req_ready; writes consume no FIFO credit and produce no response.
REQ-027 Read latency: read accepted in cycle n SHALL give rsp_valid no earlier than cycle n+L+1, exactly n+L+1 when the FIFO is empty.
REQ-028 Throughput: with rsp_ready held 1, a continuous read stream SHALL be accepted every cycle with no req_ready deassertion.
REQ-029 Ordering: responses SHALL leave in read-accept order; a write to address A accepted before a read of A SHALL be reflected in that read's data.
REQ-030 Simultaneous push and pop in one cycle: FIFO count unchanged, both operations take effect; pop of the last entry with a simultaneous push leaves rsp_valid 1 next cycle.
REQ-031 Full: FIFO overflow SHALL be impossible by REQ-025; push while full is a design error flagged by a simulation assertion.
REQ-032 FIFO pointers wrap modulo D; D need not be a power of two.
REQ-033 rsp_valid held with rsp_ready 0: rsp_data SHALL stay stable until popped.
REQ-034 busy = (any in-flight flag) | (FIFO not empty).

Reset
REQ-035 While RST_N = 0 at a rising edge, all in-flight flags, FIFO pointers, and counts SHALL clear.
REQ-036 During and after reset: rsp_valid = 0, busy = 0, req_ready = 1 from the first cycle after RST_N returns to 1.
REQ-037 Reads in flight at reset SHALL be discarded; bram_do content during or after reset SHALL NOT be pushed.
REQ-038 req_ready SHALL be 0 while RST_N = 0, so bram_en = 0 during reset.

Verification
REQ-039 PIPELINED=0: write A=3 D=0x5A, then read A=3 next cycle, rsp_ready=1 -> rsp_valid exactly 2 cycles after the read accept with rsp_data=0x5A.
REQ-040 PIPELINED=1: 8 back-to-back reads of addresses 0..7 preloaded with 0x10..0x17, rsp_ready=1 -> req_ready stays 1, responses 0x10..0x17 in order on 8 consecutive cycles starting 3 cycles after the first accept.
REQ-041 Backpressure: rsp_ready=0, continuous reads -> exactly D reads accepted (3 for PIPELINED=0, 4 for PIPELINED=1), then req_ready=0; raising rsp_ready drains all in order with no loss or duplication.
REQ-042 Simultaneous push/pop at count 1, steady stream with rsp_ready=1 -> FIFO count stays 1, no bubble on rsp_valid.
REQ-043 Reset mid-operation: 2 reads in flight and 1 buffered, assert RST_N=0 for 1 cycle -> rsp_valid=0 and busy=0 after reset, no stale response ever appears, req_ready=1.
REQ-044 Writes only, rsp_ready=0, 20 writes -> all accepted every cycle, rsp_valid stays 0, busy stays 0.
